// File: rtl/eth_rx_fcs_check.sv
// Ethernet RX FCS check: CRC-32 over each frame, strips the 4-byte FCS through a 4-byte delay line, length limits, status and counters.
// Bytes leave 1 cycle after byte i+4 arrives, txeop 1 cycle after the close strobe; no backpressure, input is never stalled.
module eth_rx_fcs_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxsop,
    input  logic [7:0]  rxdata,
    input  logic        rxvalid,
    input  logic        rxeop,
    output logic        txsop,
    output logic [7:0]  txdata,
    output logic        txvalid,
    output logic        txeop,
    output logic        fcs_ok,
    output logic        runt,
    output logic        giant,
    output logic        abort,
    output logic [11:0] txlen,
    output logic [31:0] good_count,
    output logic [31:0] bad_count
);
    localparam logic [0:0]  S_IDLE      = 1'b0;
    localparam logic [0:0]  S_FRAME     = 1'b1;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [11:0] MIN_L       = 12'(MIN_LEN);
    localparam logic [11:0] MAX_L       = 12'(MAX_LEN);
    localparam logic [11:0] FWD_MAX     = 12'(MAX_LEN - 4);

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    logic [0:0]  state;
    logic [31:0] crc;
    logic [11:0] len;
    logic [11:0] fwd;
    logic [7:0]  dbuf [0:3];
    logic [2:0]  fill;
    logic        sop_pend;
    logic        sop_dly;
    logic        is_abort;
    logic        frame_good;
    logic        start;

    assign is_abort   = rxsop && !rxeop;
    assign frame_good = !is_abort && (crc == CRC_RESIDUE) && (len >= MIN_L) && (len <= MAX_L);
    // A sop inside a frame both closes it and immediately reopens the next one.
    assign start      = (state == S_IDLE) ? (rxsop || sop_pend)
                                          : is_abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            crc        <= CRC_INIT;
            len        <= '0;
            fwd        <= '0;
            fill       <= '0;
            sop_pend   <= 1'b0;
            sop_dly    <= 1'b0;
            for (int i = 0; i < 4; i++) dbuf[i] <= '0;
            txsop      <= 1'b0;
            txdata     <= '0;
            txvalid    <= 1'b0;
            txeop      <= 1'b0;
            fcs_ok     <= 1'b0;
            runt       <= 1'b0;
            giant      <= 1'b0;
            abort      <= 1'b0;
            txlen      <= '0;
            good_count <= '0;
            bad_count  <= '0;
        end else begin
            txsop    <= sop_dly;
            txvalid  <= 1'b0;
            txeop    <= 1'b0;
            sop_dly  <= 1'b0;
            sop_pend <= 1'b0;
            if (state == S_IDLE) begin
                if (rxsop || sop_pend) begin
                    state <= S_FRAME;
                    txsop <= 1'b1;
                end
            end else if (rxsop || rxeop) begin
                // The four bytes still in dbuf are the FCS and are dropped here.
                txeop  <= 1'b1;
                fcs_ok <= !is_abort && (crc == CRC_RESIDUE);
                runt   <= len < MIN_L;
                giant  <= len > MAX_L;
                abort  <= is_abort;
                txlen  <= fwd;
                if (frame_good) good_count <= good_count + 32'd1;
                else            bad_count  <= bad_count + 32'd1;
                if (is_abort) begin
                    sop_dly <= 1'b1;
                end else begin
                    state    <= S_IDLE;
                    sop_pend <= rxsop;
                end
            end else if (rxvalid) begin
                crc <= crc_byte(crc, rxdata);
                if (len != 12'hFFF) len <= len + 12'd1;
                if (fill == 3'd4) begin
                    if (fwd < FWD_MAX) begin
                        txvalid <= 1'b1;
                        txdata  <= dbuf[0];
                        fwd     <= fwd + 12'd1;
                    end
                    dbuf[0] <= dbuf[1];
                    dbuf[1] <= dbuf[2];
                    dbuf[2] <= dbuf[3];
                    dbuf[3] <= rxdata;
                end else begin
                    dbuf[fill[1:0]] <= rxdata;
                    fill            <= fill + 3'd1;
                end
            end
            if (start) begin
                crc  <= CRC_INIT;
                len  <= '0;
                fwd  <= '0;
                fill <= '0;
            end
        end
    end
endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: known frames, FCS appended by a bit-serial reference CRC.
module tb_eth_rx_fcs_check;
    logic        clk = 1'b0;
    logic        reset;
    logic        rxsop;
    logic [7:0]  rxdata;
    logic        rxvalid;
    logic        rxeop;
    logic        txsop;
    logic [7:0]  txdata;
    logic        txvalid;
    logic        txeop;
    logic        fcs_ok;
    logic        runt;
    logic        giant;
    logic        abort;
    logic [11:0] txlen;
    logic [31:0] good_count;
    logic [31:0] bad_count;

    int checks   = 0;
    int failures = 0;
    int eop_n    = 0;
    int eop_snap;
    logic [7:0] got_q[$];
    logic [7:0] frm[$];

    eth_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1522)) dut (
        .clk(clk), .reset(reset), .rxsop(rxsop), .rxdata(rxdata), .rxvalid(rxvalid), .rxeop(rxeop),
        .txsop(txsop), .txdata(txdata), .txvalid(txvalid), .txeop(txeop),
        .fcs_ok(fcs_ok), .runt(runt), .giant(giant), .abort(abort), .txlen(txlen),
        .good_count(good_count), .bad_count(bad_count)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (txvalid) got_q.push_back(txdata);
        if (txeop) eop_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic s, input logic e, input logic v, input logic [7:0] d);
        rxsop = s; rxeop = e; rxvalid = v; rxdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic add_fcs();
        logic [31:0] c;
        logic fb;
        c = 32'hFFFF_FFFF;
        foreach (frm[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[k][b];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        c = ~c;
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    task automatic open_frame(input string tag);
        got_q.delete();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check({tag, "_txsop"}, txsop, 1);
    endtask

    task automatic send_bytes(input int from, input int to);
        for (int i = from; i < to; i++) step(1'b0, 1'b0, 1'b1, frm[i]);
    endtask

    task automatic check_data(input string tag, input int n);
        int mism;
        mism = 0;
        check({tag, "_nbytes"}, got_q.size(), n);
        for (int i = 0; i < got_q.size() && i < n; i++)
            if (got_q[i] !== frm[i]) mism++;
        check({tag, "_bytes"}, mism, 0);
    endtask

    initial begin
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);
        check("rst_ctl", {txsop, txvalid, txeop}, 0);
        check("rst_status", {fcs_ok, runt, giant, abort}, 0);
        check("rst_txlen", txlen, 0);
        check("rst_good", good_count, 0);
        check("rst_bad", bad_count, 0);

        // "123456789" with its known FCS
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        frm.push_back(8'h26); frm.push_back(8'h39); frm.push_back(8'hF4); frm.push_back(8'hCB);
        open_frame("t1");
        send_bytes(0, frm.size());
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("t1_txeop", txeop, 1);
        check("t1_status", {fcs_ok, runt, giant, abort}, 4'b1100);
        check("t1_txlen", txlen, 9);
        idle(2);
        check("t1_hold", {fcs_ok, runt, txeop}, 3'b110);
        check("t1_bad", bad_count, 1);
        check("t1_good", good_count, 0);
        check_data("t1", 9);

        // 60-byte minimal good frame
        frm.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'(i));
        add_fcs();
        open_frame("t2");
        send_bytes(0, frm.size());
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("t2_status", {txeop, fcs_ok, runt, giant, abort}, 5'b11000);
        check("t2_txlen", txlen, 60);
        idle(2);
        check("t2_good", good_count, 1);
        check_data("t2", 60);

        // same frame with one corrupted bit
        frm[10] = frm[10] ^ 8'h01;
        open_frame("t3");
        send_bytes(0, frm.size());
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("t3_status", {txeop, fcs_ok, runt, giant, abort}, 5'b10000);
        idle(2);
        check("t3_bad", bad_count, 2);
        check("t3_good", good_count, 1);
        check_data("t3", 60);

        // 1600-byte giant frame, forwarding capped at 1518
        frm.delete();
        for (int i = 0; i < 1596; i++) frm.push_back(8'(i));
        add_fcs();
        open_frame("t4");
        send_bytes(0, frm.size());
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("t4_status", {txeop, fcs_ok, runt, giant, abort}, 5'b11010);
        check("t4_txlen", txlen, 1518);
        idle(2);
        check("t4_bad", bad_count, 3);
        check_data("t4", 1518);

        // 20 bytes closed by a new sop
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(8'h80 + 8'(i));
        open_frame("t5");
        send_bytes(0, 20);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("t5_abort", {txeop, fcs_ok, runt, giant, abort, txsop}, 6'b101010);
        check("t5_txlen", txlen, 16);
        check_data("t5", 16);
        frm.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'(i * 3));
        add_fcs();
        got_q.delete();
        step(1'b0, 1'b0, 1'b1, frm[0]);
        check("t5_next_txsop", {txsop, txeop}, 2'b10);
        send_bytes(1, frm.size());
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("t5_next_status", {txeop, fcs_ok, runt, giant, abort}, 5'b11000);
        check("t5_next_txlen", txlen, 60);
        idle(2);
        check("t5_good", good_count, 2);
        check("t5_bad", bad_count, 4);
        check_data("t5_next", 60);

        // reset in the middle of a frame
        eop_snap = eop_n;
        open_frame("t6");
        send_bytes(0, 30);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(3);
        check("t6_no_eop", eop_n - eop_snap, 0);
        check("t6_counts", {good_count, bad_count} == 64'd0, 1);
        check("t6_status", {fcs_ok, runt, giant, abort, txlen}, 0);

        // good frame closed by simultaneous sop/eop
        open_frame("t7");
        send_bytes(0, frm.size());
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check("t7_eop", {txeop, txsop, fcs_ok, abort, runt}, 5'b10100);
        idle(1);
        check("t7_pend_sop", {txsop, txeop}, 2'b10);
        check("t7_good", good_count, 1);
        check("t7_bad", bad_count, 0);
        got_q.delete();
        send_bytes(0, frm.size());
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("t7_next_status", {txeop, fcs_ok, runt, giant, abort}, 5'b11000);
        idle(2);
        check("t7_next_good", good_count, 2);
        check_data("t7_next", 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
